// File: rtl/pebble_pkg.sv
// Shared types and constants for the pebble core: fetch FSM states,
// instruction width, default PC width and the branch-type opcode.
package pebble_pkg;

  localparam int INSTR_W      = 9;
  localparam int PC_W_DEFAULT = 8;

  // Top two instruction bits of a branch-type instruction; the same encoding
  // carries the done flag back from execute.
  localparam logic [1:0] INSTR_TYPE_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load (highest priority), increment and hold.
// Increment wraps silently modulo 2**PC_W.
module pc_reg #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: start/halt FSM, PC via pc_reg, instruction register
// with one-bubble branch flush. Define FETCH_PERF_CNT_EN to add retired_count.
module fetch_unit
  import pebble_pkg::*;
#(
  parameter int                PC_W       = pebble_pkg::PC_W_DEFAULT,
  parameter logic [PC_W-1:0]   START_ADDR = '0,
  parameter int                INSTR_W    = pebble_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               done_in,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               running,
  output logic               done
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        retired_count
`endif
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;

  logic               pc_load;
  logic [PC_W-1:0]    pc_load_val;
  logic               pc_inc;
  logic               start_accept;

  pc_reg #(
    .PC_W      (PC_W),
    .RESET_VAL (START_ADDR)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    valid_d      = valid_q;
    pc_load      = 1'b0;
    pc_load_val  = START_ADDR;
    pc_inc       = 1'b0;
    start_accept = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d      = RUN;
          pc_load      = 1'b1;
          start_accept = 1'b1;
        end
      end

      RUN: begin
        if (done_in) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (start) begin
          pc_load      = 1'b1;
          valid_d      = 1'b0;
          start_accept = 1'b1;
        end else if (branch_taken) begin
          // The word fetched this cycle is wrong-path; drop it.
          pc_load     = 1'b1;
          pc_load_val = branch_target;
          valid_d     = 1'b0;
        end else if (!stall) begin
          ir_d    = imem_data;
          valid_d = 1'b1;
          pc_inc  = 1'b1;
        end
      end

      HALT: begin
        valid_d = 1'b0;
        if (start) begin
          state_d      = RUN;
          pc_load      = 1'b1;
          start_accept = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc;
  assign instruction = ir_q;
  assign instr_valid = valid_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] retired_q;

  // An instruction retires when the decoder consumes a valid IR.
  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      retired_q <= '0;
    end else if (valid_q && !stall && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expected values hand-computed.
module tb_fetch_unit;
  import pebble_pkg::*;

  localparam int PC_W = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               done_in;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  logic [PC_W-1:0]    pc;
  logic               running;
  logic               done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        retired_count;
`endif

  logic [INSTR_W-1:0] imem [0:255];
  assign imem_data = imem[imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit #(
    .PC_W       (PC_W),
    .START_ADDR (8'h00),
    .INSTR_W    (INSTR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .done_in       (done_in),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .running       (running),
    .done          (done)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retired_count (retired_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [PC_W-1:0] e_pc,
                              input logic e_valid, input logic [INSTR_W-1:0] e_instr,
                              input logic e_run, input logic e_done);
    check({tag, ".pc"},      32'(pc),          32'(e_pc));
    check({tag, ".addr"},    32'(imem_addr),   32'(e_pc));
    check({tag, ".valid"},   32'(instr_valid), 32'(e_valid));
    if (e_valid) check({tag, ".instr"}, 32'(instruction), 32'(e_instr));
    check({tag, ".running"}, 32'(running),     32'(e_run));
    check({tag, ".done"},    32'(done),        32'(e_done));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 9'(i) ^ 9'h100;
    imem[8'h00] = 9'h0A1;
    imem[8'h01] = 9'h0B2;
    imem[8'h02] = 9'h0C3;
    imem[8'h03] = 9'h0D4;
    imem[8'h40] = 9'h1F0;
    imem[8'hFF] = 9'h1EE;

    reset = 1'b1; start = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_target = '0; done_in = 1'b0;

    // Reset state
    step();
    expect_state("reset", 8'h00, 1'b0, '0, 1'b0, 1'b0);
    check("reset.instr", 32'(instruction), 32'h0);

    // Start: no valid instruction on the first RUN cycle
    reset = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    expect_state("start", 8'h00, 1'b0, '0, 1'b1, 1'b0);
    step();
    expect_state("fetch0", 8'h01, 1'b1, 9'h0A1, 1'b1, 1'b0);
    step();
    expect_state("fetch1", 8'h02, 1'b1, 9'h0B2, 1'b1, 1'b0);

    // Stall holds everything for 3 cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("stall", 8'h02, 1'b1, 9'h0B2, 1'b1, 1'b0);
    end
    stall = 1'b0;
    step();
    expect_state("resume", 8'h03, 1'b1, 9'h0C3, 1'b1, 1'b0);

    // Taken branch: one bubble then target word
    branch_taken = 1'b1; branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    expect_state("br.bubble", 8'h40, 1'b0, '0, 1'b1, 1'b0);
    step();
    expect_state("br.target", 8'h41, 1'b1, 9'h1F0, 1'b1, 1'b0);

    // Branch beats stall
    branch_taken = 1'b1; stall = 1'b1; branch_target = 8'h40;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    expect_state("brst.bubble", 8'h40, 1'b0, '0, 1'b1, 1'b0);
    step();
    expect_state("brst.target", 8'h41, 1'b1, 9'h1F0, 1'b1, 1'b0);

    // Move to 0x12, then done_in together with branch_taken
    branch_taken = 1'b1; branch_target = 8'h12;
    step();
    branch_taken = 1'b0;
    expect_state("br12", 8'h12, 1'b0, '0, 1'b1, 1'b0);
    done_in = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    step();
    done_in = 1'b0; branch_taken = 1'b0;
    expect_state("halt", 8'h12, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("halt.hold", 8'h12, 1'b0, '0, 1'b0, 1'b1);
    end

    // Restart from HALT
    start = 1'b1;
    step();
    start = 1'b0;
    expect_state("restart", 8'h00, 1'b0, '0, 1'b1, 1'b0);
    step();
    expect_state("restart.f0", 8'h01, 1'b1, 9'h0A1, 1'b1, 1'b0);

    // Start in RUN beats a taken branch
    start = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
    step();
    start = 1'b0; branch_taken = 1'b0;
    expect_state("runstart", 8'h00, 1'b0, '0, 1'b1, 1'b0);

    // PC wrap 0xFF -> 0x00
    branch_taken = 1'b1; branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    expect_state("wrap.bubble", 8'hFF, 1'b0, '0, 1'b1, 1'b0);
    step();
    expect_state("wrap.ff", 8'h00, 1'b1, 9'h1EE, 1'b1, 1'b0);
    step();
    expect_state("wrap.00", 8'h01, 1'b1, 9'h0A1, 1'b1, 1'b0);

    // Reset mid-RUN with a valid instruction
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_state("midreset", 8'h00, 1'b0, '0, 1'b0, 1'b0);
    check("midreset.instr", 32'(instruction), 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("cnt.reset", 32'(retired_count), 32'd0);
`endif

    // IDLE ignores branch and done
    branch_taken = 1'b1; done_in = 1'b1; branch_target = 8'h40;
    step();
    branch_taken = 1'b0; done_in = 1'b0;
    expect_state("idle.ignore", 8'h00, 1'b0, '0, 1'b0, 1'b0);

    // Five unstalled valid cycles
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    expect_state("cnt.f0", 8'h01, 1'b1, 9'h0A1, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    check("cnt.first", 32'(retired_count), 32'd0);
`endif
    for (int i = 0; i < 5; i++) step();
    check("cnt.pc", 32'(pc), 32'h06);
`ifdef FETCH_PERF_CNT_EN
    check("cnt.five", 32'(retired_count), 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
